// File: rtl/next_pc_unit.sv
// Registered next-PC generator for the fetch stage. Priority is stall, then live redirect,
// then pending redirect, then predictor hit, then the sequential PC. Also keeps saturating statistics.
module next_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              INC      = 4,
  parameter int              NUM_PRED = 2,
  parameter int              CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     redirect_valid_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  input  logic [NUM_PRED-1:0]      pred_hit_i,
  input  logic [NUM_PRED*XLEN-1:0] pred_tgt_i,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          pc_inc_o,
  output logic [1:0]               src_o,
  output logic                     flush_o,
  output logic                     pend_o,
  output logic [CNT_W-1:0]         redirect_cnt_o,
  output logic [CNT_W-1:0]         pred_cnt_o
);

  localparam logic [1:0] SRC_HOLD = 2'd0;
  localparam logic [1:0] SRC_SEQ  = 2'd1;
  localparam logic [1:0] SRC_PRED = 2'd2;
  localparam logic [1:0] SRC_RDR  = 2'd3;

  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [1:0]       src_reg, src_next;
  logic             flush_reg, flush_next;
  logic             pend_reg, pend_next;
  logic [XLEN-1:0]  pend_pc_reg, pend_pc_next;
  logic [CNT_W-1:0] redirect_cnt_reg, redirect_cnt_next;
  logic [CNT_W-1:0] pred_cnt_reg, pred_cnt_next;

  logic [XLEN-1:0]  pred_tgt_arr [NUM_PRED];
  logic [XLEN-1:0]  pred_sel;
  logic             pred_any;
  logic [XLEN-1:0]  pc_seq;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRED; gi++) begin : g_tgt
      assign pred_tgt_arr[gi] = pred_tgt_i[gi*XLEN +: XLEN];
    end
  endgenerate

  // Scan from the top index down so the lowest set bit is the last one written.
  always_comb begin
    pred_sel = '0;
    pred_any = 1'b0;
    for (int k = NUM_PRED - 1; k >= 0; k--) begin
      if (pred_hit_i[k]) begin
        pred_sel = pred_tgt_arr[k];
        pred_any = 1'b1;
      end
    end
  end

  assign pc_seq = pc_reg + XLEN'(INC);

  always_comb begin
    pc_next           = pc_reg;
    src_next          = SRC_HOLD;
    flush_next        = 1'b0;
    pend_next         = pend_reg;
    pend_pc_next      = pend_pc_reg;
    redirect_cnt_next = redirect_cnt_reg;
    pred_cnt_next     = pred_cnt_reg;
    if (stall_i) begin
      if (redirect_valid_i) begin
        pend_next    = 1'b1;
        pend_pc_next = {redirect_pc_i[XLEN-1:1], 1'b0};
      end
    end else if (redirect_valid_i || pend_reg) begin
      pc_next    = redirect_valid_i ? {redirect_pc_i[XLEN-1:1], 1'b0} : pend_pc_reg;
      src_next   = SRC_RDR;
      flush_next = 1'b1;
      pend_next  = 1'b0;
      if (redirect_cnt_reg != '1) redirect_cnt_next = redirect_cnt_reg + 1'b1;
    end else if (pred_any) begin
      pc_next  = pred_sel;
      src_next = SRC_PRED;
      if (pred_cnt_reg != '1) pred_cnt_next = pred_cnt_reg + 1'b1;
    end else begin
      pc_next  = pc_seq;
      src_next = SRC_SEQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg           <= RESET_PC;
      src_reg          <= SRC_HOLD;
      flush_reg        <= 1'b0;
      pend_reg         <= 1'b0;
      pend_pc_reg      <= '0;
      redirect_cnt_reg <= '0;
      pred_cnt_reg     <= '0;
    end else begin
      pc_reg           <= pc_next;
      src_reg          <= src_next;
      flush_reg        <= flush_next;
      pend_reg         <= pend_next;
      pend_pc_reg      <= pend_pc_next;
      redirect_cnt_reg <= redirect_cnt_next;
      pred_cnt_reg     <= pred_cnt_next;
    end
  end

  assign pc_o           = pc_reg;
  assign pc_inc_o       = pc_seq;
  assign src_o          = src_reg;
  assign flush_o        = flush_reg;
  assign pend_o         = pend_reg;
  assign redirect_cnt_o = redirect_cnt_reg;
  assign pred_cnt_o     = pred_cnt_reg;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: a vector table for steady-state selection, plus
// hand sequences for stall/pending, live-over-pending, wrap, saturation and async reset.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [1:0]  pred_hit_i = '0;
  logic [63:0] pred_tgt_i = '0;
  logic [31:0] pc_o, pc_inc_o, pc2;
  logic [31:0] pc_inc2;
  logic [1:0]  src_o, src2;
  logic        flush_o, pend_o, flush2, pend2;
  logic [15:0] redirect_cnt_o, pred_cnt_o;
  logic [1:0]  rcnt2, pcnt2;

  int applied = 0;
  int miscompares = 0;

  next_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .pred_hit_i(pred_hit_i), .pred_tgt_i(pred_tgt_i),
    .pc_o(pc_o), .pc_inc_o(pc_inc_o), .src_o(src_o), .flush_o(flush_o), .pend_o(pend_o),
    .redirect_cnt_o(redirect_cnt_o), .pred_cnt_o(pred_cnt_o)
  );

  // Narrow-counter instance sharing the same stimulus, used for the saturation check.
  next_pc_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .pred_hit_i(pred_hit_i), .pred_tgt_i(pred_tgt_i),
    .pc_o(pc2), .pc_inc_o(pc_inc2), .src_o(src2), .flush_o(flush2), .pend_o(pend2),
    .redirect_cnt_o(rcnt2), .pred_cnt_o(pcnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  hit;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] pc;
    logic [1:0]  src;
    logic        fl;
    logic        pend;
    logic [15:0] rc;
    logic [15:0] pcnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic [1:0] hit, input logic [31:0] t0, input logic [31:0] t1);
    stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc;
    pred_hit_i = hit; pred_tgt_i = {t1, t0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   2'b00, 32'h0,   32'h0,   32'h4,   2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   2'b00, 32'h0,   32'h0,   32'h8,   2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   2'b00, 32'h0,   32'h0,   32'hC,   2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h100, 2'b00, 32'h0,   32'h0,   32'h100, 2'd3, 1'b1, 1'b0, 16'd1, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   2'b11, 32'h400, 32'h800, 32'h400, 2'd2, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   2'b10, 32'h400, 32'h800, 32'h800, 2'd2, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   2'b01, 32'h444, 32'h0,   32'h800, 2'd0, 1'b0, 1'b0, 16'd1, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 32'h301, 2'b00, 32'h0,   32'h0,   32'h800, 2'd0, 1'b0, 1'b1, 16'd1, 16'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h601, 2'b00, 32'h0,   32'h0,   32'h800, 2'd0, 1'b0, 1'b1, 16'd1, 16'd2};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   2'b00, 32'h0,   32'h0,   32'h600, 2'd3, 1'b1, 1'b0, 16'd2, 16'd2};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   2'b00, 32'h0,   32'h0,   32'h604, 2'd1, 1'b0, 1'b0, 16'd2, 16'd2};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFC, 2'd3, 1'b1, 1'b0, 16'd3, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   2'b00, 32'h0,   32'h0,   32'h0,   2'd1, 1'b0, 1'b0, 16'd3, 16'd2};

    // Reset values while rst_n is held low.
    #12;
    check("reset_pc", pc_o, 32'h0);
    check("reset_src", {30'h0, src_o}, 32'h0);
    check("reset_flush", {31'h0, flush_o}, 32'h0);
    check("reset_pend", {31'h0, pend_o}, 32'h0);
    check("reset_rcnt", {16'h0, redirect_cnt_o}, 32'h0);
    check("reset_pcnt", {16'h0, pred_cnt_o}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].hit, vecs[i].t0, vecs[i].t1);
      step();
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].pc);
      check($sformatf("v%0d_pc_inc", i), pc_inc_o, vecs[i].pc + 32'd4);
      check($sformatf("v%0d_src", i), {30'h0, src_o}, {30'h0, vecs[i].src});
      check($sformatf("v%0d_flush", i), {31'h0, flush_o}, {31'h0, vecs[i].fl});
      check($sformatf("v%0d_pend", i), {31'h0, pend_o}, {31'h0, vecs[i].pend});
      check($sformatf("v%0d_rcnt", i), {16'h0, redirect_cnt_o}, {16'h0, vecs[i].rc});
      check($sformatf("v%0d_pcnt", i), {16'h0, pred_cnt_o}, {16'h0, vecs[i].pcnt});
    end

    // Stall three cycles with a redirect in the second; release loads it.
    idle();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'h100, 2'b00, 32'h0, 32'h0);
    step();
    check("s3_start_pc", pc_o, 32'h100);
    drive(1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0);
    step();
    check("s3_stall1_pend", {31'h0, pend_o}, 32'h0);
    drive(1'b1, 1'b1, 32'h201, 2'b00, 32'h0, 32'h0);
    step();
    check("s3_stall2_pc", pc_o, 32'h100);
    check("s3_stall2_pend", {31'h0, pend_o}, 32'h1);
    drive(1'b1, 1'b0, 32'h0, 2'b00, 32'h0, 32'h0);
    step();
    check("s3_stall3_pc", pc_o, 32'h100);
    check("s3_stall3_pend", {31'h0, pend_o}, 32'h1);
    check("s3_stall3_flush", {31'h0, flush_o}, 32'h0);
    idle();
    step();
    check("s3_rel_pc", pc_o, 32'h200);
    check("s3_rel_flush", {31'h0, flush_o}, 32'h1);
    check("s3_rel_pend", {31'h0, pend_o}, 32'h0);
    check("s3_rel_rcnt", {16'h0, redirect_cnt_o}, 32'd2);
    step();
    check("s3_after_flush", {31'h0, flush_o}, 32'h0);
    check("s3_after_pc", pc_o, 32'h204);

    // Live redirect plus predictor hit beats a pending redirect; counted once.
    drive(1'b1, 1'b1, 32'h300, 2'b00, 32'h0, 32'h0);
    step();
    check("s4_pend", {31'h0, pend_o}, 32'h1);
    drive(1'b0, 1'b1, 32'h500, 2'b01, 32'h900, 32'h0);
    step();
    check("s4_pc", pc_o, 32'h500);
    check("s4_src", {30'h0, src_o}, 32'd3);
    check("s4_pend_clr", {31'h0, pend_o}, 32'h0);
    check("s4_rcnt", {16'h0, redirect_cnt_o}, 32'd3);
    check("s4_pcnt", {16'h0, pred_cnt_o}, 32'd0);
    idle();
    step();
    check("s4_next_pc", pc_o, 32'h504);

    // Async reset mid-cycle with a redirect pending.
    drive(1'b1, 1'b1, 32'h700, 2'b00, 32'h0, 32'h0);
    step();
    check("s6_pend_before", {31'h0, pend_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_pc", pc_o, 32'h0);
    check("s6_pend", {31'h0, pend_o}, 32'h0);
    check("s6_src", {30'h0, src_o}, 32'h0);
    check("s6_rcnt", {16'h0, redirect_cnt_o}, 32'h0);
    idle();
    #1 rst_n = 1'b1;
    step();
    check("s6_after_pc", pc_o, 32'h4);

    // Five redirects: narrow counter saturates, wide one counts; then PC wraps.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, (i == 4) ? 32'hFFFF_FFFC : 32'(i + 1) << 4, 2'b00, 32'h0, 32'h0);
      step();
    end
    check("s5_rcnt_sat", {30'h0, rcnt2}, 32'd3);
    check("s5_rcnt_wide", {16'h0, redirect_cnt_o}, 32'd5);
    check("s5_pc_top", pc_o, 32'hFFFF_FFFC);
    check("s5_pc_inc_wrap", pc_inc_o, 32'h0);
    idle();
    step();
    check("s5_pc_wrap", pc_o, 32'h0);
    check("s5_src_seq", {30'h0, src_o}, 32'd1);
    check("s5_rcnt_hold", {30'h0, rcnt2}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
